ofm_writer: RTL and testbench
=============================

# ofm_writer

Requantizes signed partial-sum results from the convolution datapath into 8-bit unsigned output-feature-map pixels and drives the OFM write port (address, wrData, wren). Sits directly upstream of the OFM memory. Accepts a run of `num_px` results per `start` pulse over a valid/ready handshake, writes them to consecutive OFM addresses from `base_addr`, and pulses `done` after the last write.

## Interface
- `SHIFT`, 4: right-shift amount applied during requantization (0..8).
- `ACC_W`, 16: width of the signed input result.

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; latches `num_px`, `base_addr`; ignored unless IDLE
- `num_px`  in  9  results in this run, 0..256
- `base_addr`  in  8  OFM address of the first pixel
- `in_valid`  in  1  `in_data` valid
- `in_data`  in  ACC_W  signed two's-complement result
- `in_ready`  out  1  block accepts `in_data` this cycle
- `address`  out  8  OFM write address
- `wrData`  out  8  OFM write data
- `wren`  out  1  OFM write enable, one pixel per cycle
- `busy`  out  1  high in RUN or FLUSH
- `done`  out  1  one-cycle pulse, run complete

## Operation
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on `start` with `num_px` != 0.
  - IDLE -> DONE on `start` with `num_px` == 0.
  - RUN -> FLUSH when the accepted count reaches the latched `num_px`.
  - FLUSH -> DONE when both pipeline stages are empty.
  - DONE -> IDLE unconditionally.
- `in_ready` = (state == RUN) and (accepted count < `num_px`).
- A transfer occurs when `in_valid` and `in_ready` are both high. No back-pressure from the OFM; `wren` is never stalled.
- Requantization, per accepted word, computed ACC_W+1 bits wide:
  - if `in_data` < 0, result is 0 (ReLU);
  - else r = (`in_data` + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >> SHIFT, round half up;
  - if r > 255, result is 255; else result is r[7:0].
- Addressing: the k-th written pixel (k = 0..`num_px`-1) goes to (`base_addr` + k) mod 256. Wrap past 255 to 0 is legal and silent.
- Write counter increments on each `wren`.
- `start` outside IDLE is ignored. Latched parameters are stable for the whole run.

## Timing
- Reset values: `in_ready`=0, `address`=0, `wrData`=0, `wren`=0, `busy`=0, `done`=0, state IDLE, counters 0, pipeline valids 0.
- Pipeline has two stages: stage 1 registers the requantized value; stage 2 registers `address`, `wrData`, `wren`.
- A transfer in cycle t produces `wren`=1 in cycle t+2. Full throughput is one pixel per cycle.
- `start` at cycle t: `busy` and `in_ready` rise at t+1.
- Last transfer at cycle t:
  - `in_ready` falls at t+1;
  - last `wren` at t+2;
  - `done`=1 at t+3 for exactly one cycle, with `busy`=0 in that cycle;
  - IDLE at t+4, so a new `start` is accepted at t+4.
- `num_px`=0: `start` at t gives `done` at t+1 and no `wren`.
- Gaps in `in_valid` produce matching gaps in `wren`. The address is not advanced on gaps.
- Between writes, `address`/`wrData` hold their last values and `wren`=0.
- `rst` mid-run: all outputs return to reset values immediately. In-flight pixels are dropped and no partial write is issued.

## Test plan
- Basic run: `base_addr`=0x10, `num_px`=4, back-to-back `in_data` = 16, 32, 7, 8 with SHIFT=4 -> `wren` on 4 consecutive cycles starting 2 cycles after the first transfer; writes 0x10:1, 0x11:2, 0x12:0, 0x13:1; `done` one cycle after the last write.
- Requant corners: `in_data` = -1, -32768, 4079, 4080, 32767 -> `wrData` = 0, 0, 255, 255, 255. Also `in_data`=24 -> 2 (round half up).
- Wrap and bubbles: `base_addr`=0xFE, `num_px`=4, `in_valid` toggled 1,0,1,1,0,1 -> addresses 0xFE, 0xFF, 0x00, 0x01 in order; `wren` gaps mirror the input gaps.
- Zero/full length: `num_px`=0 -> `done` at t+1, no `wren`. `num_px`=256 from base 0 -> all 256 addresses written once, `in_ready` low after the 256th transfer.
- Protocol: `start` pulsed during RUN -> ignored, and the count and base of the original run are unchanged. `in_valid` held high after the last transfer -> no extra `wren`.
- Reset mid-run: assert `rst` after 3 of 8 transfers -> outputs immediately 0; the next `start` with `num_px`=2 runs normally from its own `base_addr`.

Source files
------------

// File: rtl/ofm_writer_if.sv
// OFM writer port bundle: run control, valid/ready result input and the OFM write port.
interface ofm_writer_if #(
  parameter int unsigned ACC_W = 16
);
  logic             start;
  logic [8:0]       num_px;
  logic [7:0]       base_addr;
  logic             in_valid;
  logic [ACC_W-1:0] in_data;
  logic             in_ready;
  logic [7:0]       address;
  logic [7:0]       wrData;
  logic             wren;
  logic             busy;
  logic             done;

  modport master (
    output start, num_px, base_addr, in_valid, in_data,
    input  in_ready, address, wrData, wren, busy, done
  );

  modport slave (
    input  start, num_px, base_addr, in_valid, in_data,
    output in_ready, address, wrData, wren, busy, done
  );
endinterface

// File: rtl/ofm_writer.sv
// Requantizes signed partial sums to 8-bit pixels (ReLU, round-half-up shift, saturate)
// and writes a run of num_px pixels to consecutive OFM addresses through a 2-stage pipeline.
module ofm_writer #(
  parameter int unsigned SHIFT = 4,
  parameter int unsigned ACC_W = 16
) (
  input logic         clk,
  input logic         rst,
  ofm_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [ACC_W:0] RND = (ACC_W+1)'((1 << SHIFT) >> 1);

  state_t     state;
  logic [8:0] num_q;
  logic [7:0] base_q;
  logic [8:0] acc_cnt;
  logic [8:0] wr_cnt;
  logic       s1_valid;
  logic [7:0] s1_data;
  logic       xfer;

  logic [ACC_W:0] sum;
  logic [ACC_W:0] r;
  logic [7:0]     q;

  assign bus.in_ready = (state == RUN) && (acc_cnt < num_q);
  assign xfer         = bus.in_valid && bus.in_ready;

  always_comb begin
    sum = {1'b0, bus.in_data} + RND;
    r   = sum >> SHIFT;
    q   = '0;
    if (!bus.in_data[ACC_W-1]) begin
      q = (|r[ACC_W:8]) ? 8'hFF : r[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      num_q       <= '0;
      base_q      <= '0;
      acc_cnt     <= '0;
      wr_cnt      <= '0;
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      bus.address <= '0;
      bus.wrData  <= '0;
      bus.wren    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_data <= q;
      end

      bus.wren <= s1_valid;
      if (s1_valid) begin
        bus.address <= base_q + wr_cnt[7:0];
        bus.wrData  <= s1_data;
        wr_cnt      <= wr_cnt + 9'd1;
      end

      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            num_q   <= bus.num_px;
            base_q  <= bus.base_addr;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            if (bus.num_px == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            acc_cnt <= acc_cnt + 9'd1;
            if (9'(acc_cnt + 9'd1) == num_q) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // Stage 2 loads from stage 1 this edge, so an empty stage 1 means both drain now.
          if (!s1_valid) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_writer.sv
// Randomized self-checking bench for ofm_writer against a queue-based reference of the expected writes.
module tb_ofm_writer;

  localparam int unsigned SHIFT = 4;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t        expq[$];
  logic [15:0] stim[$];
  bit          vpat[$];
  int          hit[256];

  ofm_writer_if #(.ACC_W(16)) bus ();

  ofm_writer #(.SHIFT(SHIFT), .ACC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int requant(input logic [15:0] d);
    int x;
    int r;
    x = int'($signed(d));
    if (x < 0) return 0;
    r = (x + (1 << SHIFT) / 2) / (1 << SHIFT);
    return (r > 255) ? 255 : r;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.wren) begin
      if (expq.size() == 0) begin
        chk("extra_wren", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("wr_addr", bus.address, e.addr);
        chk("wr_data", bus.wrData, e.data);
        chk("wr_latency", cyc, e.cyc + 2);
        hit[bus.address]++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_address"}, bus.address, 0);
    chk({tag, "_wrData"}, bus.wrData, 0);
    chk({tag, "_wren"}, bus.wren, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  // One run: start pulse, feed stim[] under vpat/pct valid control, check drain and done timing.
  task automatic run(input int base, input int n, input int pct, input bit hold,
                     input bit poke, input int abort_after);
    int sent = 0;
    int last = 0;
    int guard = 0;
    int d = -1;
    bit first = 1;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.num_px    = 9'(n);
    bus.base_addr = 8'(base);
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.num_px    = 9'($urandom);
    bus.base_addr = 8'($urandom);
    if (n == 0) begin
      @(negedge clk);
      chk("zero_done", bus.done, 1);
      chk("zero_busy", bus.busy, 0);
      chk("zero_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("zero_done_pulse", bus.done, 0);
      return;
    end
    while (sent < n && guard < 2000) begin
      bus.in_valid = (vpat.size() > 0) ? vpat.pop_front() : ($urandom_range(99) < pct);
      bus.in_data  = (stim.size() > 0) ? stim[0] : 16'h0;
      if (poke && sent == 2) begin
        bus.start     = 1'b1;
        bus.num_px    = 9'd3;
        bus.base_addr = 8'h77;
      end
      @(negedge clk);
      if (first) begin
        chk("busy_rise", bus.busy, 1);
        chk("ready_rise", bus.in_ready, 1);
        first = 0;
      end
      if (poke) chk("busy_during_run", bus.busy, 1);
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.addr = (base + sent) & 255;
        e.data = requant(bus.in_data);
        e.cyc  = cyc;
        expq.push_back(e);
        void'(stim.pop_front());
        sent++;
        last = cyc;
        if (abort_after != 0 && sent == abort_after) begin
          #2 rst = 1'b1;
          #1 check_reset_outputs("mid_reset");
          expq.delete();
          bus.in_valid = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      guard++;
    end
    if (guard >= 2000) begin
      chk("xfer_timeout", sent, n);
      bus.in_valid = 1'b0;
      return;
    end
    bus.in_valid = hold;
    @(negedge clk);
    chk("ready_fall", bus.in_ready, 0);
    for (int i = 0; i < 8; i++) begin
      if (bus.done) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("done_time", d, last + 3);
    chk("done_busy_low", bus.busy, 0);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    bus.in_valid = 1'b0;
    chk("all_written", expq.size(), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.num_px    = '0;
    bus.base_addr = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    #12 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic run
    stim = '{16'd16, 16'd32, 16'd7, 16'd8};
    run(8'h10, 4, 100, 0, 0, 0);

    // Requantization corners
    stim = '{16'hFFFF, 16'h8000, 16'd4079, 16'd4080, 16'd32767, 16'd24};
    run(8'h30, 6, 100, 0, 0, 0);

    // Address wrap with input bubbles
    vpat = '{1, 0, 1, 1, 0, 1};
    for (int i = 0; i < 4; i++) stim.push_back(16'($urandom));
    run(8'hFE, 4, 100, 0, 0, 0);

    // Zero length
    run(8'h20, 0, 100, 0, 0, 0);

    // Full length from base 0
    foreach (hit[i]) hit[i] = 0;
    for (int i = 0; i < 256; i++) stim.push_back(16'($urandom));
    run(0, 256, 100, 0, 0, 0);
    begin
      int cnt = 0;
      foreach (hit[i]) if (hit[i] == 1) cnt++;
      chk("full_cover", cnt, 256);
    end

    // start during RUN is ignored; in_valid held after last transfer
    for (int i = 0; i < 6; i++) stim.push_back(16'($urandom_range(0, 4200)));
    run(8'h44, 6, 100, 1, 1, 0);

    // Reset after 3 of 8 transfers, then a normal short run
    for (int i = 0; i < 8; i++) stim.push_back(16'($urandom));
    run(8'h80, 8, 100, 0, 0, 3);
    stim.delete();
    stim = '{16'd100, 16'd5000};
    run(8'h5A, 2, 100, 0, 0, 0);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 40));
      stim.delete();
      for (int i = 0; i < n; i++)
        stim.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4200)) : 16'($urandom));
      run(int'($urandom_range(0, 255)), n, int'($urandom_range(30, 100)), bit'($urandom_range(0, 1)), 0, 0);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
